// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned RD_CYC_DEF = 2;
    localparam int unsigned WR_CYC_DEF = 1;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    typedef enum logic {
        PortMem = 1'b0,
        PortIf  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select between fetch and data ports.
// With MEM_ARB_RR_EN defined, simultaneous requests are resolved by the priority pointer.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic  if_req,
    input  logic  mem_req,
    input  logic  if_mask,
    input  logic  mem_mask,
`ifdef MEM_ARB_RR_EN
    input  port_e ptr,
`endif
    output logic  gnt_if,
    output logic  gnt_mem
);

    logic if_live;
    logic mem_live;

    always_comb begin
        // A port acked this cycle has a stale request; it is sampled again next cycle.
        if_live  = if_req & ~if_mask;
        mem_live = mem_req & ~mem_mask;
`ifdef MEM_ARB_RR_EN
        if (if_live && mem_live) begin
            gnt_mem = (ptr == PortMem);
            gnt_if  = (ptr == PortIf);
        end else begin
            gnt_mem = mem_live;
            gnt_if  = if_live;
        end
`else
        gnt_mem = mem_live;
        gnt_if  = if_live & ~mem_live;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter for an asynchronous SRAM with registered strobes.
// Define MEM_ARB_RR_EN to alternate grants between ports instead of fixed data-port priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RD_CYC = RD_CYC_DEF,
    parameter int unsigned WR_CYC = WR_CYC_DEF
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              pause
);

    state_e            state_q, state_d;
    port_e             port_q, port_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dq_o_d, if_rdata_d, mem_rdata_d;
    logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d;
    logic              if_ack_d, mem_ack_d;
    logic              gnt_if, gnt_mem;
`ifdef MEM_ARB_RR_EN
    port_e             ptr_q, ptr_d;
`endif

    mem_arb_grant u_grant (
        .if_req   (if_req),
        .mem_req  (mem_req),
        .if_mask  (if_ack),
        .mem_mask (mem_ack),
`ifdef MEM_ARB_RR_EN
        .ptr      (ptr_q),
`endif
        .gnt_if   (gnt_if),
        .gnt_mem  (gnt_mem)
    );

    assign pause = if_req & ~if_ack;

    // Strobes are computed for the next state so every SRAM pin comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        addr_d      = sram_addr;
        dq_o_d      = sram_dq_o;
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (gnt_mem || gnt_if) begin
                    port_d = gnt_mem ? PortMem : PortIf;
                    addr_d = gnt_mem ? mem_addr : if_addr;
                    cnt_d  = '0;
                    ce_n_d = 1'b0;
`ifdef MEM_ARB_RR_EN
                    ptr_d  = gnt_mem ? PortIf : PortMem;
`endif
                    if (gnt_mem && mem_we) begin
                        dq_o_d  = mem_wdata;
                        dq_oe_d = 1'b1;
                        state_d = StWrSetup;
                    end else begin
                        oe_n_d  = 1'b0;
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (cnt_q == CNT_W'(RD_CYC - 1)) begin
                    state_d = StIdle;
                    if (port_q == PortIf) begin
                        if_rdata_d = sram_dq_i;
                        if_ack_d   = 1'b1;
                    end else begin
                        mem_rdata_d = sram_dq_i;
                        mem_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    ce_n_d = 1'b0;
                    oe_n_d = 1'b0;
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
                cnt_d   = '0;
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            StWrPulse: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    we_n_d = 1'b0;
                end
            end
            StWrHold: begin
                state_d   = StIdle;
                mem_ack_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q    <= StIdle;
            port_q     <= PortMem;
            cnt_q      <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= PortMem;
`endif
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            sram_addr  <= addr_d;
            sram_dq_o  <= dq_o_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_dq_oe <= dq_oe_d;
            if_rdata   <= if_rdata_d;
            mem_rdata  <= mem_rdata_d;
            if_ack     <= if_ack_d;
            mem_ack    <= mem_ack_d;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks, a negedge monitor pops them.
module tb_mem_arbiter;

    logic        clk_50MHz = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [17:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [17:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, pause;

    mem_arbiter dut (
        .clk_50MHz  (clk_50MHz),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .pause      (pause)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Small SRAM model indexed by the low address byte; test addresses differ there.
    logic [15:0] sram [0:255];
    assign sram_dq_i = sram[sram_addr[7:0]];

    always @(posedge clk_50MHz) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) sram[k] <= 16'h0000;
            sram[8'h10] <= 16'hABCD;
            sram[8'h30] <= 16'h3030;
        end else if (!sram_we_n && !sram_ce_n) begin
            sram[sram_addr[7:0]] <= sram_dq_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk_50MHz) begin
        if (!rst && (if_ack || mem_ack)) begin
            check("ack_overlap", 32'(if_ack & mem_ack), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got if_ack=%0b mem_ack=%0b required none (cycle %0d)",
                         if_ack, mem_ack, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port_is_if", 32'(if_ack), 32'(mon_e.is_if));
                check("ack_cycle", 32'(cyc), 32'(mon_e.due));
                if (mon_e.chk_data)
                    check("ack_data", 32'(mon_e.is_if ? if_rdata : mem_rdata), 32'(mon_e.data));
            end
        end
    end

    task automatic apply_reset();
        rst     = 1'b1;
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        repeat (2) @(posedge clk_50MHz);
        #1 rst = 1'b0;
    endtask

    // Single mem-port read; request dropped right after acceptance.
    task automatic mem_read(input logic [17:0] addr, input logic [15:0] exp);
        int c0;
        @(posedge clk_50MHz);
        #1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = addr;
        c0       = cyc;
        sb.push_back('{is_if: 1'b0, chk_data: 1'b1, data: exp, due: c0 + 3});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50MHz);
            @(posedge clk_50MHz);
            #1;
            if (i == 0) mem_req = 1'b0;
        end
    endtask

    int c0;
    int nlow;

    initial begin
        apply_reset();

        // Reset values
        @(negedge clk_50MHz);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
        check("rst_if_rdata", 32'(if_rdata), 32'd0);
        check("rst_mem_rdata", 32'(mem_rdata), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_dq_o", 32'(sram_dq_o), 32'd0);

        // Fetch read held through its ack cycle, then dropped
        @(posedge clk_50MHz);
        #1;
        if_req  = 1'b1;
        if_addr = 18'h00010;
        c0      = cyc;
        sb.push_back('{is_if: 1'b1, chk_data: 1'b1, data: 16'hABCD, due: c0 + 3});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50MHz);
            check("if_pause", 32'(pause), (i < 3) ? 32'd1 : 32'd0);
            if (i == 1 || i == 2) begin
                check("rd_oe_n", 32'(sram_oe_n), 32'd0);
                check("rd_dq_oe", 32'(sram_dq_oe), 32'd0);
                check("rd_addr", 32'(sram_addr), 32'h00010);
            end
            @(posedge clk_50MHz);
            #1;
            if (i == 3) if_req = 1'b0;
        end
        repeat (5) @(posedge clk_50MHz);
        #1;
        check("if_rdata_held", 32'(if_rdata), 32'h0000ABCD);

        // Data write, request dropped mid-access
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 18'h08000;
        mem_wdata = 16'h1234;
        c0        = cyc;
        nlow      = 0;
        sb.push_back('{is_if: 1'b0, chk_data: 1'b0, data: 16'h0, due: c0 + 4});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50MHz);
            if (!sram_we_n) nlow++;
            check("oe_dq_overlap", 32'(sram_dq_oe & ~sram_oe_n), 32'd0);
            if (i >= 1 && i <= 3) begin
                check("wr_oe_n", 32'(sram_oe_n), 32'd1);
                check("wr_dq_oe", 32'(sram_dq_oe), 32'd1);
                check("wr_we_n", 32'(sram_we_n), (i == 2) ? 32'd0 : 32'd1);
            end
            @(posedge clk_50MHz);
            #1;
            if (i == 0) mem_req = 1'b0;
        end
        check("wr_we_low_cycles", 32'(nlow), 32'd1);
        mem_read(18'h08000, 16'h1234);

        // Simultaneous requests from a fresh reset: mem write first, fetch next
        apply_reset();
        @(posedge clk_50MHz);
        #1;
        if_req    = 1'b1;
        if_addr   = 18'h00010;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 18'h08001;
        mem_wdata = 16'h5555;
        c0        = cyc;
        sb.push_back('{is_if: 1'b0, chk_data: 1'b0, data: 16'h0, due: c0 + 4});
        sb.push_back('{is_if: 1'b1, chk_data: 1'b1, data: 16'hABCD, due: c0 + 7});
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_50MHz);
            if (i < 8) check("both_pause", 32'(pause), (i < 7) ? 32'd1 : 32'd0);
            @(posedge clk_50MHz);
            #1;
            if (i == 4) mem_req = 1'b0;
            if (i == 7) if_req = 1'b0;
        end
        repeat (3) @(posedge clk_50MHz);
        #1;
        mem_read(18'h08001, 16'h5555);

        // Reset asserted during the write pulse
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 18'h00020;
        mem_wdata = 16'h7777;
        @(negedge clk_50MHz);
        @(posedge clk_50MHz);
        #1 mem_req = 1'b0;
        @(negedge clk_50MHz);
        check("setup_we_n", 32'(sram_we_n), 32'd1);
        check("setup_ce_n", 32'(sram_ce_n), 32'd0);
        @(negedge clk_50MHz);
        check("pulse_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        @(posedge clk_50MHz);
        #1 rst = 1'b0;
        @(negedge clk_50MHz);
        check("rstwr_we_n", 32'(sram_we_n), 32'd1);
        check("rstwr_ce_n", 32'(sram_ce_n), 32'd1);
        check("rstwr_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rstwr_mem_ack", 32'(mem_ack), 32'd0);
        repeat (6) @(posedge clk_50MHz);
        #1;

`ifdef MEM_ARB_RR_EN
        // Continuous requests on both ports alternate mem, if, mem, if
        apply_reset();
        @(posedge clk_50MHz);
        #1;
        if_req   = 1'b1;
        if_addr  = 18'h00010;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 18'h00030;
        c0       = cyc;
        sb.push_back('{is_if: 1'b0, chk_data: 1'b1, data: 16'h3030, due: c0 + 3});
        sb.push_back('{is_if: 1'b1, chk_data: 1'b1, data: 16'hABCD, due: c0 + 6});
        sb.push_back('{is_if: 1'b0, chk_data: 1'b1, data: 16'h3030, due: c0 + 9});
        sb.push_back('{is_if: 1'b1, chk_data: 1'b1, data: 16'hABCD, due: c0 + 12});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_50MHz);
            @(posedge clk_50MHz);
            #1;
            if (i == 10) mem_req = 1'b0;
            if (i == 12) if_req = 1'b0;
        end
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
